// File: rtl/slice_streamer.sv
// slice_streamer: on every change of the discretized rotation angle, fetches
// that angle's LED column from a synchronous-read voxel BRAM, shifts it MSB
// first into the LED driver chain and then strobes the latch. The newest angle
// always wins: a slice in flight is never aborted, and a pending angle that is
// overwritten before it is consumed raises a one-cycle overrun pulse.
module slice_streamer #(
    parameter int ROTATIONAL_RES = 1024,
    parameter int WORD_W         = 16,
    parameter int SLICE_WORDS    = 4,
    parameter int MEM_LATENCY    = 2,
    parameter int SCLK_HALF      = 4
) (
    input  logic                                         clk_in,
    input  logic                                         rst_in,
    input  logic [$clog2(ROTATIONAL_RES)-1:0]             dtheta,
    output logic [$clog2(ROTATIONAL_RES*SLICE_WORDS)-1:0] mem_addr,
    input  logic [WORD_W-1:0]                             mem_data,
    output logic                                         sclk,
    output logic                                         sdata,
    output logic                                         latch,
    output logic                                         busy,
    output logic                                         overrun,
    output logic [15:0]                                  overrun_count
);

    localparam int TH_W    = $clog2(ROTATIONAL_RES);
    localparam int ADDR_W  = $clog2(ROTATIONAL_RES * SLICE_WORDS);
    localparam int WIDX_W  = (SLICE_WORDS > 1) ? $clog2(SLICE_WORDS) : 1;
    localparam int BIT_W   = $clog2(WORD_W) + 1;
    localparam int CNT_MAX = (MEM_LATENCY + 1 > SCLK_HALF) ? (MEM_LATENCY + 1) : SCLK_HALF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    // BRAM word address of word idx within the slice for angle theta
    function automatic logic [ADDR_W-1:0] slice_addr(input logic [TH_W-1:0]   theta,
                                                     input logic [WIDX_W-1:0] idx);
        slice_addr = ADDR_W'(theta) * ADDR_W'(SLICE_WORDS) + ADDR_W'(idx);
    endfunction

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        sat_inc = (value == 16'hFFFF) ? value : (value + 16'd1);
    endfunction

    state_t              state_r, state_n;
    logic [TH_W-1:0]     prev_theta_r, prev_theta_n;
    logic [TH_W-1:0]     pend_theta_r, pend_theta_n;
    logic                pending_r, pending_n;
    logic                armed_r, armed_n;
    logic [TH_W-1:0]     slice_theta_r, slice_theta_n;
    logic [WIDX_W-1:0]   word_idx_r, word_idx_n;
    logic [BIT_W-1:0]    bit_cnt_r, bit_cnt_n;
    logic [CNT_W-1:0]    cnt_r, cnt_n;
    logic                phase_high_r, phase_high_n;
    logic [WORD_W-1:0]   shreg_r, shreg_n;
    logic [ADDR_W-1:0]   mem_addr_r, mem_addr_n;
    logic                sclk_r, sclk_n;
    logic                sdata_r, sdata_n;
    logic                latch_r, latch_n;
    logic                busy_r, busy_n;
    logic                overrun_r, overrun_n;
    logic [15:0]         overrun_count_r, overrun_count_n;
    logic                consume_s;

    // Next-state, datapath and change-detect logic; outputs are derived from the next state so they register in step with it
    always_comb begin
        state_n         = state_r;
        prev_theta_n    = prev_theta_r;
        pend_theta_n    = pend_theta_r;
        pending_n       = pending_r;
        armed_n         = armed_r;
        slice_theta_n   = slice_theta_r;
        word_idx_n      = word_idx_r;
        bit_cnt_n       = bit_cnt_r;
        cnt_n           = cnt_r;
        phase_high_n    = phase_high_r;
        shreg_n         = shreg_r;
        mem_addr_n      = mem_addr_r;
        overrun_n       = 1'b0;
        overrun_count_n = overrun_count_r;
        consume_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // The address is issued on entry so it is stable for the whole fetch window
                if (pending_r && armed_r) begin
                    consume_s     = 1'b1;
                    slice_theta_n = pend_theta_r;
                    word_idx_n    = {WIDX_W{1'b0}};
                    cnt_n         = {CNT_W{1'b0}};
                    mem_addr_n    = slice_addr(pend_theta_r, {WIDX_W{1'b0}});
                    state_n       = ST_FETCH;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (cnt_r == CNT_W'(MEM_LATENCY)) begin
                    shreg_n      = mem_data;
                    cnt_n        = {CNT_W{1'b0}};
                    bit_cnt_n    = {BIT_W{1'b0}};
                    phase_high_n = 1'b0;
                    state_n      = ST_SHIFT;
                end else begin
                    cnt_n = cnt_r + CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_W'(SCLK_HALF - 1)) begin
                    cnt_n = {CNT_W{1'b0}};
                    if (!phase_high_r) begin
                        phase_high_n = 1'b1;
                    end else begin
                        phase_high_n = 1'b0;
                        shreg_n      = {shreg_r[WORD_W-2:0], 1'b0};
                        if (bit_cnt_r == BIT_W'(WORD_W - 1)) begin
                            if (word_idx_r == WIDX_W'(SLICE_WORDS - 1)) begin
                                state_n = ST_LATCH;
                            end else begin
                                word_idx_n = word_idx_r + WIDX_W'(1);
                                mem_addr_n = slice_addr(slice_theta_r, word_idx_r + WIDX_W'(1));
                                state_n    = ST_FETCH;
                            end
                        end else begin
                            bit_cnt_n = bit_cnt_r + BIT_W'(1);
                        end
                    end
                end else begin
                    cnt_n = cnt_r + CNT_W'(1);
                end
            end
            ST_LATCH: begin
                if (cnt_r == CNT_W'(SCLK_HALF - 1)) begin
                    cnt_n   = {CNT_W{1'b0}};
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        pending_n = consume_s ? 1'b0 : pending_r;

        // First cycle out of reset only samples the angle; afterwards every change re-arms the pending slice
        if (!armed_r) begin
            armed_n      = 1'b1;
            prev_theta_n = dtheta;
            pend_theta_n = dtheta;
        end else if (dtheta != prev_theta_r) begin
            prev_theta_n = dtheta;
            pend_theta_n = dtheta;
            pending_n    = 1'b1;
            if (pending_r && !consume_s) begin
                overrun_n       = 1'b1;
                overrun_count_n = sat_inc(overrun_count_r);
            end else begin
                overrun_n = 1'b0;
            end
        end else begin
            prev_theta_n = prev_theta_r;
        end

        sclk_n  = (state_n == ST_SHIFT) && phase_high_n;
        sdata_n = (state_n == ST_SHIFT) ? shreg_n[WORD_W-1] : 1'b0;
        latch_n = (state_n == ST_LATCH);
        busy_n  = (state_n != ST_IDLE);
    end

    // State and output registers with synchronous reset; reset aborts any slice in flight
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r         <= ST_IDLE;
            prev_theta_r    <= {TH_W{1'b0}};
            pend_theta_r    <= {TH_W{1'b0}};
            pending_r       <= 1'b1;
            armed_r         <= 1'b0;
            slice_theta_r   <= {TH_W{1'b0}};
            word_idx_r      <= {WIDX_W{1'b0}};
            bit_cnt_r       <= {BIT_W{1'b0}};
            cnt_r           <= {CNT_W{1'b0}};
            phase_high_r    <= 1'b0;
            shreg_r         <= {WORD_W{1'b0}};
            mem_addr_r      <= {ADDR_W{1'b0}};
            sclk_r          <= 1'b0;
            sdata_r         <= 1'b0;
            latch_r         <= 1'b0;
            busy_r          <= 1'b0;
            overrun_r       <= 1'b0;
            overrun_count_r <= 16'd0;
        end else begin
            state_r         <= state_n;
            prev_theta_r    <= prev_theta_n;
            pend_theta_r    <= pend_theta_n;
            pending_r       <= pending_n;
            armed_r         <= armed_n;
            slice_theta_r   <= slice_theta_n;
            word_idx_r      <= word_idx_n;
            bit_cnt_r       <= bit_cnt_n;
            cnt_r           <= cnt_n;
            phase_high_r    <= phase_high_n;
            shreg_r         <= shreg_n;
            mem_addr_r      <= mem_addr_n;
            sclk_r          <= sclk_n;
            sdata_r         <= sdata_n;
            latch_r         <= latch_n;
            busy_r          <= busy_n;
            overrun_r       <= overrun_n;
            overrun_count_r <= overrun_count_n;
        end
    end

    assign mem_addr      = mem_addr_r;
    assign sclk          = sclk_r;
    assign sdata         = sdata_r;
    assign latch         = latch_r;
    assign busy          = busy_r;
    assign overrun       = overrun_r;
    assign overrun_count = overrun_count_r;

endmodule
